// File: rtl/mc_controller.sv
// Control FSM for the multicycle RV32I datapath with a memory-ready wait-state handshake.
// Optional feature: define MC_BNE_EN to accept bne (funct3=001) in BRANCH.
module mc_controller #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_REG = 2'b10;
  localparam logic [1:0] B_REG = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;

  // Where an unsupported opcode/funct3 sends the FSM: sticky trap or silent skip.
  localparam state_t ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? TRAP : FETCH;

  state_t     state_q, state_d;
  logic       illegal_q;
  logic [2:0] alu_op;
  logic       alu_ok;
  logic       branch_ok;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    alu_op = ALU_ADD;
    alu_ok = 1'b1;
    case (funct3)
      3'b000:  alu_op = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      3'b100:  alu_op = ALU_XOR;
      default: alu_ok = 1'b0;
    endcase
  end

`ifdef MC_BNE_EN
  assign branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
`else
  assign branch_ok = (funct3 == 3'b000);
`endif

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = A_PC;
    ALUSrcB    = B_REG;
    ALUControl = ALU_ADD;
    instr_done = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB   = B_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = A_OLDPC;
        ALUSrcB = B_IMM;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BR:        state_d = BRANCH;
          OP_JAL:       state_d = JAL;
          default:      state_d = ILLEGAL_NEXT;
        endcase
      end
      MEMADR: begin
        ALUSrcA = A_REG;
        ALUSrcB = B_IMM;
        state_d = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end
      EXECR, EXECI: begin
        ALUSrcA    = A_REG;
        ALUSrcB    = (state_q == EXECI) ? B_IMM : B_REG;
        ALUControl = alu_op;
        state_d    = alu_ok ? ALUWB : ILLEGAL_NEXT;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = A_REG;
        ALUControl = ALU_SUB;
        if (branch_ok) begin
          // funct3[0] inverts the sense of Zero, turning beq into bne.
          PCWrite    = Zero ^ funct3[0];
          instr_done = 1'b1;
          state_d    = FETCH;
        end else begin
          state_d = ILLEGAL_NEXT;
        end
      end
      JAL: begin
        ALUSrcA = A_OLDPC;
        ALUSrcB = B_FOUR;
        PCWrite = 1'b1;
        state_d = ALUWB;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      if (state_d == TRAP) illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller: per-cycle state and control-vector checks.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, instr_done}
  logic [14:0] vec;
  assign vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, instr_done};

  localparam logic [14:0] V_FETCH   = {5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0};
  localparam logic [14:0] V_FWAIT   = {5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0};
  localparam logic [14:0] V_DECODE  = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0};
  localparam logic [14:0] V_MEMADR  = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0};
  localparam logic [14:0] V_MEMREAD = {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [14:0] V_MEMWB   = {5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 1'b1};
  localparam logic [14:0] V_MEMWR   = {5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [14:0] V_MEMWR_D = {5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1};
  localparam logic [14:0] V_ALUWB   = {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1};
  localparam logic [14:0] V_JAL     = {5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0};
  localparam logic [14:0] V_TRAP    = 15'd0;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

  function automatic logic [14:0] exec_v(input logic is_r, input logic [2:0] ac);
    return {5'b00000, 2'b00, 2'b10, (is_r ? 2'b00 : 2'b01), ac, 1'b0};
  endfunction

  function automatic logic [14:0] br_v(input logic pcw, input logic done);
    return {pcw, 4'b0000, 2'b00, 2'b10, 2'b00, 3'b001, done};
  endfunction

  logic [3:0]  obs_state [32];
  logic [14:0] obs_vec   [32];
  logic        obs_ill   [32];
  logic [1:0]  obs_imm   [32];

  // Drives mem_ready from bit i of mr in cycle i and records outputs mid-cycle.
  task automatic capture(input int n, input logic [31:0] mr);
    for (int i = 0; i < n; i++) begin
      mem_ready = mr[i];
      #1;
      obs_state[i] = state;
      obs_vec[i]   = vec;
      obs_ill[i]   = illegal;
      obs_imm[i]   = ImmSrc;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    mem_ready = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || vec !== V_FWAIT) begin
      failures++;
      $display("FAIL reset_hold: state=%0d illegal=%b vec=%b, expected 0 0 %b", state, illegal, vec, V_FWAIT);
    end
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || vec !== V_FETCH) begin
      failures++;
      $display("FAIL reset_first_fetch: state=%0d vec=%b, expected 0 %b", state, vec, V_FETCH);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_lw();
    logic [3:0]  es[$];
    logic [14:0] ev[$];
    int done_cnt = 0;
    op = OP_LW; funct3 = 3'b010;
    capture(6, 32'h1F);
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    ev = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB, V_FWAIT};
    for (int i = 0; i < es.size(); i++) begin
      done_cnt += int'(obs_vec[i][0]);
      checks++;
      if (obs_state[i] !== es[i] || obs_vec[i] !== ev[i]) begin
        failures++;
        $display("FAIL lw c%0d: state=%0d vec=%b, expected %0d %b", i, obs_state[i], obs_vec[i], es[i], ev[i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || obs_imm[0] !== 2'b00) begin
      failures++;
      $display("FAIL lw_done_imm: done=%0d imm=%b, expected 1 00", done_cnt, obs_imm[0]);
    end
  endtask

  task automatic test_wait_states();
    logic [3:0]  es[$];
    logic [14:0] ev[$];
    op = OP_LW;
    capture(8, 32'h6E);
    es = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd0};
    ev = '{V_FWAIT, V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMREAD, V_MEMWB, V_FWAIT};
    for (int i = 0; i < es.size(); i++) begin
      checks++;
      if (obs_state[i] !== es[i] || obs_vec[i] !== ev[i]) begin
        failures++;
        $display("FAIL lw_wait c%0d: state=%0d vec=%b, expected %0d %b", i, obs_state[i], obs_vec[i], es[i], ev[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [3:0]  es[$];
    logic [14:0] ev[$];
    op = OP_SW;
    capture(8, 32'h47);
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    ev = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_MEMWR, V_MEMWR, V_MEMWR_D, V_FWAIT};
    for (int i = 0; i < es.size(); i++) begin
      checks++;
      if (obs_state[i] !== es[i] || obs_vec[i] !== ev[i]) begin
        failures++;
        $display("FAIL sw c%0d: state=%0d vec=%b, expected %0d %b", i, obs_state[i], obs_vec[i], es[i], ev[i]);
      end
    end
    checks++;
    if (obs_imm[0] !== 2'b01) begin
      failures++;
      $display("FAIL sw_imm: imm=%b, expected 01", obs_imm[0]);
    end
  endtask

  task automatic test_alu();
    logic [6:0]  c_op [7];
    logic [2:0]  c_f3 [7];
    logic        c_f7 [7];
    logic [2:0]  c_ac [7];
    logic        is_r;
    logic [3:0]  es[$];
    logic [14:0] ev[$];
    c_op = '{OP_R, OP_R, OP_R, OP_R, OP_I, OP_I, OP_R};
    c_f3 = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b000, 3'b010, 3'b000};
    c_f7 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    c_ac = '{3'b001, 3'b100, 3'b011, 3'b010, 3'b000, 3'b101, 3'b000};
    for (int k = 0; k < 7; k++) begin
      op = c_op[k]; funct3 = c_f3[k]; funct7b5 = c_f7[k];
      is_r = (c_op[k] == OP_R);
      capture(5, 32'h0F);
      es = '{4'd0, 4'd1, (is_r ? 4'd6 : 4'd7), 4'd8, 4'd0};
      ev = '{V_FETCH, V_DECODE, exec_v(is_r, c_ac[k]), V_ALUWB, V_FWAIT};
      for (int i = 0; i < es.size(); i++) begin
        checks++;
        if (obs_state[i] !== es[i] || obs_vec[i] !== ev[i]) begin
          failures++;
          $display("FAIL alu%0d c%0d: state=%0d vec=%b, expected %0d %b", k, i, obs_state[i], obs_vec[i], es[i], ev[i]);
        end
      end
    end
    funct7b5 = 1'b0;
  endtask

  task automatic test_beq();
    logic [3:0]  es[$];
    logic [14:0] ev[$];
    op = OP_BR; funct3 = 3'b000;
    for (int z = 1; z >= 0; z--) begin
      Zero = z[0];
      capture(4, 32'h07);
      es = '{4'd0, 4'd1, 4'd9, 4'd0};
      ev = '{V_FETCH, V_DECODE, br_v(z[0], 1'b1), V_FWAIT};
      for (int i = 0; i < es.size(); i++) begin
        checks++;
        if (obs_state[i] !== es[i] || obs_vec[i] !== ev[i]) begin
          failures++;
          $display("FAIL beq z%0d c%0d: state=%0d vec=%b, expected %0d %b", z, i, obs_state[i], obs_vec[i], es[i], ev[i]);
        end
      end
    end
    checks++;
    if (obs_imm[0] !== 2'b10) begin
      failures++;
      $display("FAIL beq_imm: imm=%b, expected 10", obs_imm[0]);
    end
    Zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [3:0]  es[$];
    logic [14:0] ev[$];
    op = OP_JAL;
    capture(5, 32'h0F);
    es = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
    ev = '{V_FETCH, V_DECODE, V_JAL, V_ALUWB, V_FWAIT};
    for (int i = 0; i < es.size(); i++) begin
      checks++;
      if (obs_state[i] !== es[i] || obs_vec[i] !== ev[i]) begin
        failures++;
        $display("FAIL jal c%0d: state=%0d vec=%b, expected %0d %b", i, obs_state[i], obs_vec[i], es[i], ev[i]);
      end
    end
    checks++;
    if (obs_imm[0] !== 2'b11) begin
      failures++;
      $display("FAIL jal_imm: imm=%b, expected 11", obs_imm[0]);
    end
  endtask

  task automatic test_reset_mid();
    op = OP_LW;
    capture(3, 32'h01);
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || vec !== V_FWAIT) begin
      failures++;
      $display("FAIL reset_mid: state=%0d vec=%b, expected 0 %b", state, vec, V_FWAIT);
    end
    @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hold: state=%0d rw=%b mw=%b, expected 0 0 0", state, RegWrite, MemWrite);
    end
    reset = 1'b1;
  endtask

  task automatic test_illegal_op();
    logic [3:0]  e_s;
    logic [14:0] e_v;
    op = 7'b1111111;
    capture(22, 32'hFFFF_FFFF);
    for (int i = 0; i < 22; i++) begin
      e_s = (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : 4'd11;
      e_v = (i == 0) ? V_FETCH : (i == 1) ? V_DECODE : V_TRAP;
      checks++;
      if (obs_state[i] !== e_s || obs_vec[i] !== e_v || obs_ill[i] !== (i >= 2)) begin
        failures++;
        $display("FAIL illegal_op c%0d: state=%0d vec=%b ill=%b, expected %0d %b %b",
                 i, obs_state[i], obs_vec[i], obs_ill[i], e_s, e_v, (i >= 2));
      end
    end
    checks++;
    if (obs_imm[0] !== 2'b00) begin
      failures++;
      $display("FAIL illegal_imm: imm=%b, expected 00", obs_imm[0]);
    end
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL trap_clear: state=%0d illegal=%b, expected 0 0", state, illegal);
    end
    reset = 1'b1;
  endtask

  task automatic test_illegal_funct3();
    logic [3:0]  es[$];
    logic [14:0] ev[$];
    op = OP_R; funct3 = 3'b001;
    capture(4, 32'h07);
    es = '{4'd0, 4'd1, 4'd6, 4'd11};
    ev = '{V_FETCH, V_DECODE, exec_v(1'b1, 3'b000), V_TRAP};
    for (int i = 0; i < es.size(); i++) begin
      checks++;
      if (obs_state[i] !== es[i] || obs_vec[i] !== ev[i] || obs_ill[i] !== (i == 3)) begin
        failures++;
        $display("FAIL bad_f3 c%0d: state=%0d vec=%b ill=%b, expected %0d %b", i, obs_state[i], obs_vec[i], obs_ill[i], es[i], ev[i]);
      end
    end
    pulse_reset();
    op = OP_BR; funct3 = 3'b001; Zero = 1'b1;
    capture(4, 32'h07);
`ifdef MC_BNE_EN
    es = '{4'd0, 4'd1, 4'd9, 4'd0};
    ev = '{V_FETCH, V_DECODE, br_v(1'b0, 1'b1), V_FWAIT};
`else
    es = '{4'd0, 4'd1, 4'd9, 4'd11};
    ev = '{V_FETCH, V_DECODE, br_v(1'b0, 1'b0), V_TRAP};
`endif
    for (int i = 0; i < es.size(); i++) begin
      checks++;
      if (obs_state[i] !== es[i] || obs_vec[i] !== ev[i]) begin
        failures++;
        $display("FAIL bne c%0d: state=%0d vec=%b, expected %0d %b", i, obs_state[i], obs_vec[i], es[i], ev[i]);
      end
    end
    pulse_reset();
    Zero = 1'b0; funct3 = 3'b000;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_wait_states();
    test_sw();
    test_alu();
    test_beq();
    test_jal();
    test_reset_mid();
    test_illegal_funct3();
    test_illegal_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control FSM for the multicycle RV32I datapath, which uses a shared instruction/data memory, an instruction register (IR), an OldPC register, and ALU/Data registers.
- Sequences fetch, decode, execute and writeback over 3–5 cycles per instruction.
- Adds a memory-ready wait-state handshake.
- Supports lw, sw, R-type and I-type ALU ops (add, sub, and, or, xor, slt), beq and jal.

Parameters:
- TRAP_ON_ILLEGAL, 1, 1 = an illegal opcode or funct3 enters the sticky TRAP state; 0 = it returns to FETCH and the instruction is skipped.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  shared-memory access complete this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR/OldPC load enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register A.
- ALUSrcB  out  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  sticky; set on entry to TRAP.
- state  out  4  current state, for debug.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=11.
- Reset (reset=0, asynchronous): state=FETCH and illegal=0. All outputs are decoded combinationally from state, so they immediately take their FETCH values.
- Outputs not listed for a state are 0. No X is ever driven.
- ImmSrc is decoded purely from op, in every state: lw/I-type → 00, sw → 01, beq → 10, jal → 11, anything else → 00.
- FETCH:
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10.
  - IRWrite and PCWrite are asserted only while mem_ready=1.
  - Holds in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01, add (computes the branch/jal target).
  - Next state by op: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL.
  - Any other op → TRAP, or FETCH if TRAP_ON_ILLEGAL=0.
- MEMADR:
  - Drives ALUSrcA=10, ALUSrcB=01, add.
  - Goes to MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD: drives AdrSrc=1, ResultSrc=00; holds until mem_ready=1, then → MEMWB.
- MEMWB: drives ResultSrc=01, RegWrite=1, instr_done=1; → FETCH.
- MEMWRITE:
  - Drives AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MemWrite stays high while mem_ready=0.
  - When mem_ready=1: instr_done=1 and → FETCH.
- EXECR: drives ALUSrcA=10, ALUSrcB=00; → ALUWB.
- EXECI: drives ALUSrcA=10, ALUSrcB=01; → ALUWB.
- ALU decode for EXECR and EXECI, by funct3:
  - 000: sub if funct7b5 & op[5], otherwise add.
  - 010 → slt; 110 → or; 111 → and; 100 → xor.
  - Any other funct3 → TRAP, or FETCH with no write if TRAP_ON_ILLEGAL=0.
- ALUWB: drives ResultSrc=00, RegWrite=1, instr_done=1; → FETCH.
- BRANCH:
  - Drives ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = Zero for funct3=000.
  - instr_done=1; → FETCH.
- JAL:
  - Drives ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
  - → ALUWB, which writes PC+4 to rd.
- TRAP: all strobes are 0; illegal=1; the FSM stays in TRAP until reset.
- Reset asserted mid-instruction aborts the instruction immediately. No further RegWrite or MemWrite pulse is issued.
- Cycles per instruction with mem_ready always 1: lw 5, sw 4, R/I 4, beq 3, jal 4. Each wait cycle adds one.

Optional Feature:
- Macro: MC_BNE_EN.
- Defined: BRANCH also accepts funct3=001 (bne), with PCWrite = Zero ^ funct3[0].
- Undefined: funct3=001 in BRANCH is illegal and is handled like an illegal funct3 (→ TRAP or skip per TRAP_ON_ILLEGAL). beq behaviour is unchanged.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release → state=0, illegal=0, all strobes 0 except FETCH's gated strobes; IRWrite=PCWrite=1 in the first cycle with mem_ready=1.
- lw with mem_ready=1: op=0000011 → states visit 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01 only in state 4; instr_done pulses exactly once.
- sw with mem_ready low for 3 cycles in MEMWRITE: op=0100011 → MemWrite=1 and AdrSrc=1 for 4 consecutive cycles; instr_done=1 only in the 4th.
- R-type: op=0110011, funct3=000, funct7b5=1 → ALUControl=001 in EXECR. Then funct3=100 → ALUControl=100 (xor); ALUWB asserts RegWrite=1.
- beq: op=1100011, funct3=000, Zero=1 → PCWrite=1 in BRANCH. With Zero=0 → PCWrite=0; the next state is FETCH in both cases.
- Illegal: op=1111111 with TRAP_ON_ILLEGAL=1 → state=11, illegal=1, held for 20 cycles; asserting reset=0 clears it to state=0.
